inst_fetch_buf: RTL

- Instruction fetch stage sitting directly upstream of the instruction ROM.
- Owns the PC and drives the ROM's ce/addr. The ROM returns a 64-bit instruction combinationally in the same cycle.
- Captures each {pc, inst} pair into a small prefetch FIFO.
- Presents the FIFO head to the IF/ID boundary with a valid/ready handshake.
- Handles branch redirect by flushing the FIFO and reloading the PC.

---
 rtl/inst_fetch_buf.sv | 95 +++++++++
 1 files changed

// File: rtl/inst_fetch_buf.sv
// inst_fetch_buf: instruction fetch stage that owns the PC, drives the instruction ROM and buffers {pc, inst} pairs for decode.
//   clk, rst (async, active-low)
//   rom_ce_o / rom_addr_o / rom_inst_i : instruction ROM interface (combinational read)
//   branch_flag_i / branch_target_i    : redirect from execute
//   id_valid_o / id_ready_i / id_pc_o / id_inst_o : FIFO head towards decode
//   FETCH_PERF_CNT_EN adds fetch_cnt_o and bubble_cnt_o performance counters.
module inst_fetch_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 64,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic              pop, fetch, push;
  assign rom_ce_o   = ce_q;
  assign rom_addr_o = pc_q;
  assign id_valid_o = count_q != '0;
  always_comb begin
    pop   = id_valid_o & id_ready_i;
    // a full FIFO popping this cycle frees its slot in time for the push
    fetch = ce_q & ((count_q < CW'(DEPTH)) | pop);
    push  = fetch & ~branch_flag_i;
    ce_d  = 1'b1;
    id_pc_o   = id_valid_o ? pc_mem[rd_ptr_q] : '0;
    id_inst_o = id_valid_o ? inst_mem[rd_ptr_q] : '0;
    pc_d     = branch_flag_i ? {branch_target_i[ADDR_W-1:3], 3'b000} : fetch ? pc_q + ADDR_W'(8) : pc_q;
    count_d  = branch_flag_i ? '0 : count_q + CW'(fetch) - CW'(pop);
    rd_ptr_d = branch_flag_i ? '0 : rd_ptr_q + PW'(pop);
    wr_ptr_d = branch_flag_i ? '0 : wr_ptr_q + PW'(fetch);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      ce_q     <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ce_q     <= ce_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
  // storage needs no reset: outputs are masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= rom_inst_i;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(fetch);
    bubble_cnt_d = bubble_cnt_q + 32'(ce_q & ~id_valid_o);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
`endif
endmodule
